// File: rtl/alu_issue_ctrl.sv
// Purpose: operand-fetch / issue / writeback controller sitting in front of the ALU, with an NREG x n register bank.
// Latency: accept edge to writeback edge is ALU_LAT cycles; peak throughput is one instruction per ALU_LAT+1 cycles.
// Backpressure: instr_ready is low while EXEC is in progress and in any IDLE cycle where a preload (load_en) takes priority.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   load_en/load_addr/load_data     register bank preload (IDLE only, wins over instructions)
//   instr_valid/instr_ready         instruction handshake; instr_op/rd/rs/rt carry the instruction
//   R2, R3, ALUOp                   registered operands and opcode to the ALU
//   R1, overflow_in/zero_in/carry_in  ALU result and flags, sampled at the writeback edge
//   wb_valid/wb_rd/wb_data          one-cycle writeback report
//   overflow/zero/carry             sticky status flags, updated only on writeback
//   busy                            high while in EXEC
//   dbg_addr/dbg_data               combinational debug read port (register 0 reads 0)
module alu_issue_ctrl #(
    parameter int n       = 32,
    parameter int NREG    = 8,
    parameter int AW      = 3,
    parameter int ALU_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [n-1:0]  load_data,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic [2:0]    instr_op,
    input  logic [AW-1:0] instr_rd,
    input  logic [AW-1:0] instr_rs,
    input  logic [AW-1:0] instr_rt,
    output logic [n-1:0]  R2,
    output logic [n-1:0]  R3,
    output logic [2:0]    ALUOp,
    input  logic [n-1:0]  R1,
    input  logic          overflow_in,
    input  logic          zero_in,
    input  logic          carry_in,
    output logic          wb_valid,
    output logic [AW-1:0] wb_rd,
    output logic [n-1:0]  wb_data,
    output logic          overflow,
    output logic          zero,
    output logic          carry,
    output logic          busy,
    input  logic [AW-1:0] dbg_addr,
    output logic [n-1:0]  dbg_data
);

    // Counter only needs to hold ALU_LAT-1.
    localparam int             CW       = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
    localparam logic [CW-1:0]  CNT_INIT = CW'(ALU_LAT - 1);
    localparam logic [2:0]     OP_NOP   = 3'b111;

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [AW-1:0]   rd_q;
    logic [n-1:0]    bank [NREG];

    assign busy        = (state == EXEC);
    assign instr_ready = (state == IDLE) && !load_en;
    assign dbg_data    = (dbg_addr == '0) ? '0 : bank[dbg_addr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            rd_q     <= '0;
            R2       <= '0;
            R3       <= '0;
            ALUOp    <= '0;
            wb_valid <= 1'b0;
            wb_rd    <= '0;
            wb_data  <= '0;
            overflow <= 1'b0;
            zero     <= 1'b0;
            carry    <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                bank[i] <= '0;
            end
        end else begin
            // Writeback report is a single-cycle pulse.
            wb_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_en) begin
                        // Register 0 is hardwired to zero; drop writes to it.
                        if (load_addr != '0) begin
                            bank[load_addr] <= load_data;
                        end
                    end else if (instr_valid && (instr_op != OP_NOP)) begin
                        R2    <= bank[instr_rs];
                        R3    <= bank[instr_rt];
                        ALUOp <= instr_op;
                        rd_q  <= instr_rd;
                        cnt   <= CNT_INIT;
                        state <= EXEC;
                    end
                    // An accepted NOP simply completes in IDLE.
                end
                EXEC: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        if (rd_q != '0) begin
                            bank[rd_q] <= R1;
                        end
                        overflow <= overflow_in;
                        zero     <= zero_in;
                        carry    <= carry_in;
                        wb_valid <= 1'b1;
                        wb_rd    <= rd_q;
                        wb_data  <= R1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Operand-fetch, issue and writeback controller sitting directly upstream of the ALU.
- Holds an NREG x n register bank and accepts instructions over a valid/ready handshake.
- Drives R2/R3/ALUOp into the ALU, waits ALU_LAT cycles, then captures R1 and the overflow/zero/carry flags.
- Writes the result back to the bank and presents a one-cycle writeback pulse plus sticky status flags.

Parameters:
- n, 32, datapath width
- NREG, 8, register bank depth (power of two)
- AW, 3, register address width, equal to log2(NREG)
- ALU_LAT, 1, cycles from operand issue to result sampling (at least 1)

Ports:
- clk  in  1  clock, all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- load_en  in  1  preload strobe for the register bank
- load_addr  in  AW  preload target
- load_data  in  n  preload value
- instr_valid  in  1  instruction offered
- instr_ready  out  1  instruction accepted when valid and ready are both high on a clock edge
- instr_op  in  3  ALU opcode: 000 MOV, 001 NOT, 010 ADD, 011 NOR, 100 SUB, 101 NAND, 110 SLT, 111 NOP
- instr_rd  in  AW  destination register
- instr_rs  in  AW  source register, drives R2
- instr_rt  in  AW  source register, drives R3
- R2  out  n  ALU operand A (registered)
- R3  out  n  ALU operand B (registered)
- ALUOp  out  3  ALU opcode (registered)
- R1  in  n  ALU result
- overflow_in  in  1  ALU overflow flag
- zero_in  in  1  ALU zero flag
- carry_in  in  1  ALU carry flag
- wb_valid  out  1  one-cycle pulse, a writeback occurred
- wb_rd  out  AW  register written
- wb_data  out  n  value written
- overflow  out  1  status flag, updated only on writeback
- zero  out  1  status flag, updated only on writeback
- carry  out  1  status flag, updated only on writeback
- busy  out  1  high while in EXEC
- dbg_addr  in  AW  debug read address
- dbg_data  out  n  combinational read of bank[dbg_addr]; reads 0 when dbg_addr is 0

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; all bank entries 0; R2, R3, ALUOp, wb_rd, wb_data all 0; wb_valid, overflow, zero, carry, busy all 0; internal counter 0.
  - Reset asserted mid-EXEC aborts the instruction: no writeback, flags stay 0.
- Register 0 always reads 0. Writes to it (preload or writeback) are discarded, but wb_valid still pulses with wb_rd=0 and the computed wb_data.
- FSM states: IDLE and EXEC.
- IDLE:
  - instr_ready = !load_en.
  - load_en high: bank[load_addr] <= load_data; no instruction is accepted that cycle (load has priority).
  - Accept with op != 111:
    - R2 <= bank[instr_rs], R3 <= bank[instr_rt], ALUOp <= instr_op, and the destination rd is latched.
    - counter <= ALU_LAT-1; state goes to EXEC.
  - Accept with op = 111: no operand update, no writeback, no wb_valid, flags unchanged; remains in IDLE.
- EXEC:
  - instr_ready = 0, busy = 1; load_en is ignored.
  - R2, R3 and ALUOp are held stable.
  - counter != 0: decrement the counter.
  - counter == 0, on that edge:
    - bank[rd] <= R1; overflow/zero/carry <= the _in flags.
    - wb_rd <= rd, wb_data <= R1, wb_valid <= 1.
    - state goes to IDLE.
- Latency and throughput:
  - Accept edge to writeback edge is ALU_LAT cycles.
  - wb_valid is high for the single cycle after the writeback edge; instr_ready is high in that same cycle.
  - Peak throughput is one instruction per ALU_LAT+1 cycles.
- Hazards: writeback completes before the next accept, so a back-to-back dependent instruction (rs or rt equal to the previous rd) reads the new value. No forwarding logic is needed.
- rs = rt = rd is legal; operands are the old value and the destination receives the result.
- wb_valid deasserts the cycle after its pulse unless a new writeback occurs (impossible within one cycle when ALU_LAT is at least 1).
- Operands are n-bit and passed through unmodified. The block performs no arithmetic itself.

Test Plan:
1. Preload r1=421, r2=3. Issue MOV rd=3 rs=1 -> R2=421 and ALUOp=000 the cycle after accept; with the ALU model returning R1=421, after ALU_LAT cycles wb_valid pulses with wb_rd=3, wb_data=421, and dbg_addr=3 reads 421.
2. Preload r1=r2=FFFFFFFF. Issue ADD rd=4 rs=1 rt=2 -> wb_data=FFFFFFFE, carry=1, overflow=0; flags persist unchanged across the next NOP.
3. Back-to-back dependency: SUB r5=r1-r1, then ADD r6=r5+r2 on the first ready cycle -> second issue shows R2=0 (the new r5); zero=1 after the first writeback.
4. load_en and instr_valid high together in IDLE -> instr_ready=0, load performed; instruction accepted the next cycle. load_en during EXEC -> bank unchanged.
5. Write to r0 via preload and via writeback of SLT 7FFFFFFF vs 80000001 -> dbg_data at addr 0 stays 0; wb_valid still pulses with wb_rd=0.
6. Assert rst_n low mid-EXEC with ALU_LAT=3 -> all outputs 0 immediately, no wb_valid after release, instr_ready=1 on the first cycle after reset release.
